twi_arbiter: RTL and testbench
==============================

# twi_arbiter

Round-robin arbiter and sequencer that shares one `twi_master` between up to N_REQ on-chip requesters. It accepts per-requester write/read commands and latches the winner's chip address, register address and write data. It drives the master's level-sensitive `wr`/`rd` controller interface and monitors the bus lines to detect transaction start and completion. It returns a done pulse and read data to the owner, then enforces a bus-free gap before the next grant.

## Interface
- N_REQ, 4, number of requesters (2..8)
- GAP, 64, idle cycles enforced after each transaction before the next grant (≥ 1)
- TIMEOUT, 65535, watchdog limit in cycles from grant (only with `TWI_ARB_TIMEOUT_EN`)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- req_wr  in  N_REQ  per-requester write request, level, held until own done
- req_rd  in  N_REQ  per-requester read request, level, held until own done
- req_chip_addr  in  7*N_REQ  packed 7-bit slave addresses, requester i at [7i+6:7i]
- req_reg_addr  in  8*N_REQ  packed register addresses
- req_wdata  in  8*N_REQ  packed write data
- gnt  out  N_REQ  one-hot owner, high from grant through RELEASE
- done  out  N_REQ  one-cycle completion pulse to owner
- err  out  N_REQ  one-cycle timeout pulse, coincident with done
- rdata  out  8  read data, valid in the done cycle and held until next done
- busy  out  1  high in every state except IDLE
- twi_chip_addr, twi_reg_addr, twi_datain  out  7/8/8  to master, from latched command
- twi_wr, twi_rd  out  1  to master `wr`/`rd`
- twi_dataout  in  8  from master `dataout`
- twi_scl, twi_sda  in  1  bus monitor taps

## Operation
- `twi_scl` and `twi_sda` each pass through a 2-flop synchronizer. Edge logic uses the synced values and their 1-cycle-delayed copies.
  - START_DET: scl_s=1 and sda_s falls.
  - STOP_DET: scl_s=1 and sda_s rises.
- States:
  - IDLE → ISSUE when any req_wr|req_rd is high and the gap counter is 0.
  - ISSUE → XFER on START_DET.
  - XFER → RELEASE on STOP_DET. Repeated-start edges in XFER are ignored.
  - RELEASE → GAP unconditionally (1 cycle).
  - GAP → IDLE after GAP cycles.
- Arbitration is round-robin. The search starts at the index after the last granted requester; after reset it starts at 0.
- On grant, latch chip_addr, reg_addr, wdata and the operation. If both req_wr and req_rd are high, the write wins.
- twi_wr/twi_rd are high through ISSUE and XFER and low from RELEASE onward. This guarantees the master sees the level across its START window and returns to WAIT without restarting.
- RELEASE:
  - Capture rdata ← twi_dataout for reads; writes leave rdata unchanged.
  - Pulse done[owner] and advance the round-robin pointer.
- A requester that drops its request after grant does not abort the transfer; done still pulses. Dropping before grant simply withdraws the request.
- New requests arriving while busy wait; no queue depth beyond the level inputs.

## Timing
- Reset values: gnt=0, done=0, err=0, rdata=0x00, busy=0, twi_wr=0, twi_rd=0, twi_* address/data=0, RR pointer=0, gap counter=0, state IDLE.
- Grant latency: request seen in IDLE at cycle k gives gnt, busy, twi_wr/rd and latched fields registered at k+1.
- START_DET and STOP_DET are visible 3 cycles after the bus edge (2 sync + 1 edge register).
- done is asserted the cycle after STOP_DET is registered; twi_wr/twi_rd fall in the same cycle.
- Minimum spacing from done to the next twi_wr rise is GAP+1 cycles.
- Reset mid-transaction: all outputs return to reset values on the next edge; no done is issued. The master shares rst.

## Configuration
- `TWI_ARB_TIMEOUT_EN` defined:
  - A 16-bit watchdog clears at grant and counts in ISSUE and XFER.
  - When it reaches TIMEOUT, go to RELEASE with done[owner]=err[owner]=1 and rdata forced to 0x00. Then go through GAP as normal.
- Undefined: no counter; err is constant 0; ISSUE/XFER wait indefinitely.

## Test plan
- Write on req0 (chip 0x50, reg 0x10, data 0xA5) with master+ACKing slave model → bus bytes 0xA0, 0x10, 0xA5; gnt=0001; one done[0]; err=0.
- Read on req1 (chip 0x21, reg 0x04), slave returns 0x3C → rdata=0x3C in done[1] cycle and held afterward.
- All four requesters assert together after reset → completion order 0,1,2,3; each next twi_wr rise ≥ GAP+1 cycles after prior done.
- req2 asserts both wr and rd → write sequence on bus, done[2] once, rdata unchanged.
- rst low for 1 cycle during XFER → all outputs zero next cycle; held request is re-granted and completes normally.
- With macro and TIMEOUT=200, bench holds sda low (no STOP) → done[0]=err[0]=1 exactly 200 cycles after grant; rdata=0x00.

Source files
------------

// File: rtl/twi_arbiter.sv
// twi_arbiter: round-robin sequencer sharing one twi_master among N_REQ requesters.
// Optional watchdog enabled by defining TWI_ARB_TIMEOUT_EN.
module twi_arbiter #(
    parameter int N_REQ   = 4,
    parameter int GAP     = 64,
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_wr,
    input  logic [N_REQ-1:0]   req_rd,
    input  logic [7*N_REQ-1:0] req_chip_addr,
    input  logic [8*N_REQ-1:0] req_reg_addr,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [N_REQ-1:0]   err,
    output logic [7:0]         rdata,
    output logic               busy,
    output logic [6:0]         twi_chip_addr,
    output logic [7:0]         twi_reg_addr,
    output logic [7:0]         twi_datain,
    output logic               twi_wr,
    output logic               twi_rd,
    input  logic [7:0]         twi_dataout,
    input  logic               twi_scl,
    input  logic               twi_sda
);
    localparam int PW = $clog2(N_REQ);
    localparam int GW = $clog2(GAP + 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_XFER, S_RELEASE, S_GAP} state_t;
    state_t r_state, w_next;

    logic [1:0]       r_scl_s, r_sda_s;
    logic             r_sda_d, r_start_det, r_stop_det;
    logic [N_REQ-1:0] r_gnt, w_req;
    logic [PW-1:0]    r_ptr, r_own, w_idx;
    logic             w_found, w_timeout, w_act, r_wr, r_to;
    logic [GW-1:0]    r_gap;
    logic [6:0]       r_chip;
    logic [7:0]       r_reg, r_wd, r_rdata;

    // Bus monitor: two-flop synchronizers, then registered START/STOP detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scl_s     <= 2'b11;
            r_sda_s     <= 2'b11;
            r_sda_d     <= 1'b1;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_scl_s     <= {r_scl_s[0], twi_scl};
            r_sda_s     <= {r_sda_s[0], twi_sda};
            r_sda_d     <= r_sda_s[1];
            r_start_det <= r_scl_s[1] & r_sda_d & ~r_sda_s[1];
            r_stop_det  <= r_scl_s[1] & ~r_sda_d & r_sda_s[1];
        end
    end

    assign w_req = req_wr | req_rd;

    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && w_req[(int'(r_ptr) + i) % N_REQ]) begin
                w_found = 1'b1;
                w_idx   = PW'((int'(r_ptr) + i) % N_REQ);
            end
        end
    end

`ifdef TWI_ARB_TIMEOUT_EN
    logic [15:0] r_wdog;
    assign w_timeout = w_act && r_wdog == 16'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!rst)
            r_wdog <= '0;
        else if (r_state == S_IDLE)
            r_wdog <= '0;
        else if (w_act)
            r_wdog <= r_wdog + 16'd1;
    end
    assign err = (r_state == S_RELEASE && r_to) ? r_gnt : '0;
`else
    assign w_timeout = 1'b0 && (TIMEOUT == 0);
    assign err       = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = (w_found && r_gap == '0) ? S_ISSUE : S_IDLE;
            S_ISSUE:   w_next = w_timeout ? S_RELEASE : (r_start_det ? S_XFER : S_ISSUE);
            S_XFER:    w_next = (w_timeout || r_stop_det) ? S_RELEASE : S_XFER;
            S_RELEASE: w_next = S_GAP;
            S_GAP:     w_next = (r_gap == '0) ? S_IDLE : S_GAP;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_own   <= '0;
            r_gap   <= '0;
            r_wr    <= 1'b0;
            r_to    <= 1'b0;
            r_chip  <= '0;
            r_reg   <= '0;
            r_wd    <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == S_IDLE && w_next == S_ISSUE) begin
                r_gnt  <= {{(N_REQ-1){1'b0}}, 1'b1} << w_idx;
                r_own  <= w_idx;
                r_wr   <= req_wr[w_idx];
                r_to   <= 1'b0;
                r_chip <= req_chip_addr[7*int'(w_idx) +: 7];
                r_reg  <= req_reg_addr[8*int'(w_idx) +: 8];
                r_wd   <= req_wdata[8*int'(w_idx) +: 8];
            end
            // Capture on entry to RELEASE so rdata is already valid in the done cycle
            if (w_act && w_next == S_RELEASE) begin
                r_rdata <= w_timeout ? 8'h00 : (r_wr ? r_rdata : twi_dataout);
                r_to    <= w_timeout;
            end
            if (r_state == S_RELEASE) begin
                r_gnt <= '0;
                r_ptr <= (int'(r_own) == N_REQ - 1) ? '0 : r_own + 1'b1;
                r_gap <= GW'(GAP - 1);
            end
            if (r_state == S_GAP && r_gap != '0)
                r_gap <= r_gap - 1'b1;
        end
    end

    assign w_act         = r_state == S_ISSUE || r_state == S_XFER;
    assign gnt           = r_gnt;
    assign done          = (r_state == S_RELEASE) ? r_gnt : '0;
    assign busy          = r_state != S_IDLE;
    assign rdata         = r_rdata;
    assign twi_wr        = w_act & r_wr;
    assign twi_rd        = w_act & ~r_wr;
    assign twi_chip_addr = r_chip;
    assign twi_reg_addr  = r_reg;
    assign twi_datain    = r_wd;
endmodule

// File: tb/tb_twi_arbiter.sv
// tb_twi_arbiter: directed scoreboard bench with a cycle-scripted bus responder.
module tb_twi_arbiter;
    localparam int N = 4, GP = 8, TO = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b0;
    logic [N-1:0]   req_wr = '0, req_rd = '0;
    logic [7*N-1:0] req_chip_addr = '0;
    logic [8*N-1:0] req_reg_addr = '0, req_wdata = '0;
    logic [N-1:0]   gnt, done, err;
    logic [7:0]     rdata, twi_reg_addr, twi_datain;
    logic [6:0]     twi_chip_addr;
    logic           busy, twi_wr, twi_rd;
    logic [7:0]     twi_dataout = '0;
    logic           twi_scl = 1'b1, twi_sda = 1'b1;

    twi_arbiter #(.N_REQ(N), .GAP(GP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_wr(req_wr), .req_rd(req_rd),
        .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .twi_chip_addr(twi_chip_addr), .twi_reg_addr(twi_reg_addr), .twi_datain(twi_datain),
        .twi_wr(twi_wr), .twi_rd(twi_rd), .twi_dataout(twi_dataout),
        .twi_scl(twi_scl), .twi_sda(twi_sda)
    );

    typedef struct {
        int         own;
        bit         wr;
        logic [6:0] chip;
        logic [7:0] rg, wd, rd;
        bit         er;
    } exp_t;
    exp_t q[$];

    int         checks = 0, errors = 0, cyc = 0, done_cyc = 0, g_cyc = 0, bt = 0;
    bit         done_ok = 0, no_stop = 0, p_act = 0;
    logic [7:0] slave_rd = '0;
    logic [N-1:0] p_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs, score grants/dones, then advance the bus script
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (gnt != '0 && p_gnt == '0) begin
            g_cyc = cyc;
            if (q.size() == 0) chk("grant_unexpected", 32'(gnt), 0);
            else begin
                chk("gnt", 32'(gnt), 1 << q[0].own);
                chk("chip", 32'(twi_chip_addr), 32'(q[0].chip));
                chk("reg", 32'(twi_reg_addr), 32'(q[0].rg));
                chk("wdata", 32'(twi_datain), 32'(q[0].wd));
                chk("twi_wr", 32'(twi_wr), 32'(q[0].wr));
                chk("twi_rd", 32'(twi_rd), 32'(!q[0].wr));
                chk("busy", 32'(busy), 1);
            end
        end
        if ((twi_wr | twi_rd) && !p_act && done_ok)
            chk("gap_spacing", 32'(cyc - done_cyc >= GP + 1), 1);
        if (done != '0) begin
            done_cyc = cyc;
            done_ok  = 1;
            if (q.size() == 0) chk("done_unexpected", 32'(done), 0);
            else begin
                chk("done", 32'(done), 1 << q[0].own);
                chk("err", 32'(err), q[0].er ? (1 << q[0].own) : 0);
                chk("rdata", 32'(rdata), 32'(q[0].rd));
                chk("gnt_at_done", 32'(gnt), 1 << q[0].own);
                chk("wr_rd_low", 32'(twi_wr | twi_rd), 0);
                void'(q.pop_front());
            end
        end
        p_gnt = gnt;
        p_act = twi_wr | twi_rd;
        if (!(twi_wr | twi_rd)) begin
            bt = 0; twi_scl = 1'b1; twi_sda = 1'b1;
        end else begin
            bt++;
            case (bt)
                2:  twi_sda = 1'b0;
                8:  twi_scl = 1'b0;
                10: twi_sda = 1'b1;
                12: twi_scl = 1'b1;
                14: twi_sda = 1'b0;
                18: begin twi_scl = 1'b0; twi_dataout = slave_rd; end
                22: if (!no_stop) twi_scl = 1'b1;
                26: if (!no_stop) twi_sda = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic set_req(input int i, input bit w, input bit r,
                           input logic [6:0] c, input logic [7:0] rg, input logic [7:0] wd);
        req_chip_addr[7*i +: 7] = c;
        req_reg_addr[8*i +: 8]  = rg;
        req_wdata[8*i +: 8]     = wd;
        req_wr[i] = w;
        req_rd[i] = r;
    endtask

    task automatic push(input int o, input bit w, input logic [6:0] c, input logic [7:0] rg,
                        input logic [7:0] wd, input logic [7:0] rd, input bit er);
        exp_t e;
        e.own = o; e.wr = w; e.chip = c; e.rg = rg; e.wd = wd; e.rd = rd; e.er = er;
        q.push_back(e);
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (!done[i] && n < budget) begin tick(); n++; end
        chk($sformatf("done_seen_%0d", i), 32'(done[i]), 1);
        req_wr[i] = 1'b0;
        req_rd[i] = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", 32'(rdata), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_twi_wr", 32'(twi_wr), 0);
        chk("rst_twi_rd", 32'(twi_rd), 0);
        chk("rst_chip", 32'(twi_chip_addr), 0);
        chk("rst_reg", 32'(twi_reg_addr), 0);
        chk("rst_datain", 32'(twi_datain), 0);
    endtask

    initial begin
        repeat (3) tick();
        chk_reset();
        rst = 1'b1;
        tick();

        set_req(0, 1, 0, 7'h50, 8'h10, 8'hA5);
        push(0, 1, 7'h50, 8'h10, 8'hA5, 8'h00, 0);
        wait_done(0, 300);

        slave_rd = 8'h3C;
        set_req(1, 0, 1, 7'h21, 8'h04, 8'h00);
        push(1, 0, 7'h21, 8'h04, 8'h00, 8'h3C, 0);
        wait_done(1, 300);
        repeat (5) tick();
        chk("rdata_hold", 32'(rdata), 32'h3C);

        rst = 1'b0;
        tick();
        chk_reset();
        rst = 1'b1;
        done_ok = 0;
        slave_rd = 8'h77;
        for (int i = 0; i < N; i++) begin
            set_req(i, i != 3, i == 3, 7'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i));
            push(i, i != 3, 7'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), (i == 3) ? 8'h77 : 8'h00, 0);
        end
        for (int i = 0; i < N; i++) wait_done(i, 300);

        slave_rd = 8'h99;
        set_req(2, 1, 1, 7'h2A, 8'h0B, 8'h5E);
        push(2, 1, 7'h2A, 8'h0B, 8'h5E, 8'h77, 0);
        wait_done(2, 300);
        repeat (5) tick();
        chk("rdata_unchanged", 32'(rdata), 32'h77);

        set_req(1, 1, 0, 7'h33, 8'h44, 8'h55);
        push(1, 1, 7'h33, 8'h44, 8'h55, 8'h00, 0);
        begin
            int n = 0;
            while (bt < 12 && n < 300) begin tick(); n++; end
        end
        chk("reached_xfer", 32'(bt >= 12), 1);
        rst = 1'b0;
        tick();
        chk_reset();
        rst = 1'b1;
        done_ok = 0;
        wait_done(1, 300);

`ifdef TWI_ARB_TIMEOUT_EN
        no_stop = 1;
        set_req(0, 1, 0, 7'h50, 8'h10, 8'hA5);
        push(0, 1, 7'h50, 8'h10, 8'hA5, 8'h00, 1);
        wait_done(0, 400);
        chk("timeout_latency", 32'(done_cyc - g_cyc), TO);
        no_stop = 0;
`endif

        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
